stg2if: RTL and testbench
=========================

Name: stg2if

Overview:
- Instruction-fetch stage, directly downstream of the instruction-address stage.
- Pairs each valid fetch slot (pc, predictor info) with the instruction word memory returns one cycle after the address was driven.
- Buffers pairs in a small FIFO so decode can stall without dropping in-flight fetches.
- Requests upstream hold when the buffer nears full; flushes on redirect.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, minimum 4.
- AW, $clog2(DEPTH), pointer width. Derived; not overridden.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset; asynchronous, active-high
- iw_flush  in  1  redirect/flush; empties the stage
- iw_pc  in  `SIZE_ADDR  pc of the slot presented by the address stage
- iw_ia_valid  in  1  slot valid
- iw_pred_pc  in  `SIZE_ADDR  predicted next pc of the slot
- iw_pred_taken  in  1  prediction taken flag
- iw_mem_data  in  `SIZE_DATA  instruction word for iw_pc; valid in the same cycle as iw_ia_valid
- iw_stall  in  1  downstream (decode) cannot accept this cycle
- ow_pc  out  `SIZE_ADDR  head entry pc
- ow_instr  out  `SIZE_DATA  head entry instruction
- ow_pred_pc  out  `SIZE_ADDR  head entry predicted pc
- ow_pred_taken  out  1  head entry prediction flag
- ow_if_valid  out  1  head entry valid
- ow_hold  out  1  upstream pc must not advance
- ow_overflow  out  1  sticky error: push attempted while full
- ow_stall_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (async, iw_rst=1): wr_ptr=0, rd_ptr=0, count=0, ow_overflow=0, ow_stall_cnt=0.
  - ow_if_valid=0, ow_hold=0.
  - Data outputs read storage; contents unspecified, ignored while ow_if_valid=0.
- Entry = {pc, instr, pred_pc, pred_taken}; storage is DEPTH registers, no reset required on data.
- push = iw_ia_valid & ~iw_flush.
  - On the clock edge: write entry at wr_ptr; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- pop = ow_if_valid & ~iw_stall & ~iw_flush.
  - On the clock edge: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
- count: AW+1 bits.
  - push only: +1. pop only: −1. Both: unchanged.
- ow_if_valid = (count != 0). Outputs come combinationally from storage[rd_ptr].
- Latency: slot accepted at edge t appears at outputs in cycle t+1 when the FIFO is empty. No combinational bypass from inputs to outputs.
- Simultaneous push and pop when full: legal. Pop frees the slot and push writes it; count stays DEPTH, no overflow.
- Push while count==DEPTH and no pop: entry dropped, pointers unchanged, ow_overflow <= 1. Sticky until reset.
- ow_hold = (count >= DEPTH−2), combinational.
  - The two-slot margin absorbs the address-stage latch plus the address already on the memory bus.
- Flush, iw_flush=1 at edge: wr_ptr <= 0, rd_ptr <= 0, count <= 0.
  - Any same-cycle push and pop are discarded.
  - ow_if_valid=0 in the following cycle; flush has priority over every other event.
- Stall with count==0: no effect.
- Decode samples head outputs only when ow_if_valid=1 and iw_stall=0.
- Head outputs are stable across a stall, except after a flush.
- Reset mid-stream: all state cleared immediately, asynchronously; partially stored entries are lost.

Optional Feature:
- Macro: STG2IF_PERF_EN.
- Defined: ow_stall_cnt is a 32-bit counter.
  - Increments on each edge where ow_if_valid & iw_stall.
  - Wraps at 2^32−1 → 0.
  - Cleared only by reset; flush does not clear it.
- Not defined: ow_stall_cnt tied to 32'h0 and no counter register is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Streaming: reset, then 8 consecutive valid slots pc=0x10..0x17, iw_stall=0.
  - ow_if_valid rises 1 cycle after the first push.
  - Outputs pc 0x10..0x17 in order with the matching instr.
  - ow_hold stays 0 and count never exceeds 1.
- Stall fill: hold iw_stall=1 and push 4 slots.
  - ow_hold=1 once count reaches 2; count reaches 4 and ow_overflow stays 0.
  - Release stall: 4 entries drain in order, one per cycle.
- Overflow: keep stalling at count=4 and push pc=0x40.
  - ow_overflow=1 and count stays 4.
  - Draining never presents pc 0x40.
- Flush: count=3 with a simultaneous push and flush.
  - Next cycle ow_if_valid=0, count=0.
  - A later push of pc=0x80 appears after 1 cycle.
- Wrap: push/pop continuously for 3×DEPTH entries.
  - Pointer wrap loses no entries and reorders none.
  - Full-and-simultaneous push/pop keeps count at DEPTH.
- Perf (STG2IF_PERF_EN defined): 5 stall cycles with ow_if_valid=1, then 2 with an empty FIFO.
  - ow_stall_cnt=5.
  - With the macro undefined, ow_stall_cnt stays 0.

Source files
------------

// File: rtl/stg2if.sv
// stg2if -- instruction-fetch stage.
//
// Pairs each valid fetch slot from the address stage (pc, predicted pc,
// predicted-taken flag) with the instruction word that memory returns in
// the same cycle. Pairs are queued in a DEPTH-entry FIFO so decode can stall
// without losing fetches that are already in flight. The stage asks the
// address stage to hold once the FIFO is within two slots of full, and a
// redirect flush empties it.
//
// Ports:
//   iw_clk, iw_rst      clock; asynchronous active-high reset
//   iw_flush            redirect: discard everything queued this edge
//   iw_pc, iw_ia_valid  slot from the address stage
//   iw_pred_pc          predicted next pc of the slot
//   iw_pred_taken       prediction taken flag of the slot
//   iw_mem_data         instruction word for iw_pc (same cycle)
//   iw_stall            decode cannot accept the head this cycle
//   ow_pc, ow_instr, ow_pred_pc, ow_pred_taken   head entry fields
//   ow_if_valid         head entry is valid
//   ow_hold             address stage must not advance its pc
//   ow_overflow         sticky: a push was attempted while full
//   ow_stall_cnt        cycles with a valid head held off by decode
//
// Build option: define STG2IF_PERF_EN to include the 32-bit stall counter;
// without it ow_stall_cnt is a constant zero.

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module stg2if #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                  iw_clk,
   input  logic                  iw_rst,
   input  logic                  iw_flush,
   input  logic [`SIZE_ADDR-1:0] iw_pc,
   input  logic                  iw_ia_valid,
   input  logic [`SIZE_ADDR-1:0] iw_pred_pc,
   input  logic                  iw_pred_taken,
   input  logic [`SIZE_DATA-1:0] iw_mem_data,
   input  logic                  iw_stall,
   output logic [`SIZE_ADDR-1:0] ow_pc,
   output logic [`SIZE_DATA-1:0] ow_instr,
   output logic [`SIZE_ADDR-1:0] ow_pred_pc,
   output logic                  ow_pred_taken,
   output logic                  ow_if_valid,
   output logic                  ow_hold,
   output logic                  ow_overflow,
   output logic [31:0]           ow_stall_cnt
);

   localparam int EW = 2 * `SIZE_ADDR + `SIZE_DATA + 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] HOLD_CNT = (AW+1)'(DEPTH - 2);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic push;
   logic pop;
   logic full;
   logic wr_en;

   assign full  = (count == FULL_CNT);
   assign push  = iw_ia_valid & ~iw_flush;
   assign pop   = ow_if_valid & ~iw_stall & ~iw_flush;
   // A push into a full FIFO only lands if the head leaves in the same edge.
   assign wr_en = push & (~full | pop);

   assign ow_if_valid = (count != '0);
   assign ow_hold     = (count >= HOLD_CNT);
   assign {ow_pc, ow_instr, ow_pred_pc, ow_pred_taken} = mem[rd_ptr];

   // Storage: data only, no reset needed.
   always_ff @(posedge iw_clk) begin
      if (wr_en)
         mem[wr_ptr] <= {iw_pc, iw_mem_data, iw_pred_pc, iw_pred_taken};
   end

   // Control: pointers, occupancy and sticky overflow.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         ow_overflow <= 1'b0;
      end else if (iw_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push & full & ~pop)
            ow_overflow <= 1'b1;
      end
   end

`ifdef STG2IF_PERF_EN
   logic [31:0] stall_cnt;

   // Counts edges where decode refused a valid head; flush leaves it alone.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst)
         stall_cnt <= 32'h0;
      else if (ow_if_valid & iw_stall)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign ow_stall_cnt = stall_cnt;
`else
   assign ow_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_stg2if.sv
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_stg2if;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  flush = 1'b0;
   logic [`SIZE_ADDR-1:0] pc = '0;
   logic                  ia_valid = 1'b0;
   logic [`SIZE_ADDR-1:0] pred_pc = '0;
   logic                  pred_taken = 1'b0;
   logic [`SIZE_DATA-1:0] mem_data = '0;
   logic                  stall = 1'b0;
   logic [`SIZE_ADDR-1:0] o_pc;
   logic [`SIZE_DATA-1:0] o_instr;
   logic [`SIZE_ADDR-1:0] o_pred_pc;
   logic                  o_pred_taken;
   logic                  o_valid;
   logic                  o_hold;
   logic                  o_ovf;
   logic [31:0]           o_scnt;

   int total = 0;
   int bad   = 0;

   stg2if #(.DEPTH(4)) dut (
      .iw_clk       (clk),
      .iw_rst       (rst),
      .iw_flush     (flush),
      .iw_pc        (pc),
      .iw_ia_valid  (ia_valid),
      .iw_pred_pc   (pred_pc),
      .iw_pred_taken(pred_taken),
      .iw_mem_data  (mem_data),
      .iw_stall     (stall),
      .ow_pc        (o_pc),
      .ow_instr     (o_instr),
      .ow_pred_pc   (o_pred_pc),
      .ow_pred_taken(o_pred_taken),
      .ow_if_valid  (o_valid),
      .ow_hold      (o_hold),
      .ow_overflow  (o_ovf),
      .ow_stall_cnt (o_scnt)
   );

   always #5 clk = ~clk;

   // Memory model: instruction word and prediction derived from the pc.
   function automatic logic [`SIZE_DATA-1:0] instr_of(input logic [`SIZE_ADDR-1:0] a);
      return `SIZE_DATA'(a * 32'h0001_0003) ^ `SIZE_DATA'(32'hC3A5_0F00);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [`SIZE_ADDR-1:0] p,
                        input logic s, input logic f);
      ia_valid   = v;
      pc         = p;
      mem_data   = instr_of(p);
      pred_pc    = p + 4;
      pred_taken = p[0];
      stall      = s;
      flush      = f;
   endtask

   task automatic chk_head(input string name, input logic [`SIZE_ADDR-1:0] p);
      chk({name, ".pc"},      64'(o_pc),         64'(p));
      chk({name, ".instr"},   64'(o_instr),      64'(instr_of(p)));
      chk({name, ".pred_pc"}, 64'(o_pred_pc),    64'(p + 4));
      chk({name, ".taken"},   64'(o_pred_taken), 64'(p[0]));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [31:0] p;
      logic        s;
      logic        f;
      logic        ev;
      logic [31:0] ep;
      logic        eh;
      logic        eo;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(input logic v, input logic [31:0] p, input logic s,
                               input logic f, input logic ev, input logic [31:0] ep,
                               input logic eh, input logic eo);
      vec_t r;
      r.v = v; r.p = p; r.s = s; r.f = f; r.ev = ev; r.ep = ep; r.eh = eh; r.eo = eo;
      return r;
   endfunction

   logic [`SIZE_ADDR-1:0] q[$];
   logic [`SIZE_ADDR-1:0] nxt;
   logic                  mvalid;
   logic                  mpop;
   int                    exp_perf;

   initial begin
      // Streaming: one entry in flight, head trails the input by one cycle.
      tbl[0] = mk(1, 32'h10, 0, 0, 0, 32'h0,  0, 0);
      for (int i = 1; i < 8; i++)
         tbl[i] = mk(1, 32'h10 + 32'(i), 0, 0, 1, 32'h10 + 32'(i - 1), 0, 0);
      tbl[8]  = mk(0, 32'h0,  0, 0, 1, 32'h17, 0, 0);
      tbl[9]  = mk(0, 32'h0,  0, 0, 0, 32'h0,  0, 0);
      // Stall fill to 4, then overflow attempt with pc 0x40.
      tbl[10] = mk(1, 32'h20, 1, 0, 0, 32'h0,  0, 0);
      tbl[11] = mk(1, 32'h21, 1, 0, 1, 32'h20, 0, 0);
      tbl[12] = mk(1, 32'h22, 1, 0, 1, 32'h20, 1, 0);
      tbl[13] = mk(1, 32'h23, 1, 0, 1, 32'h20, 1, 0);
      tbl[14] = mk(1, 32'h40, 1, 0, 1, 32'h20, 1, 0);
      tbl[15] = mk(0, 32'h0,  1, 0, 1, 32'h20, 1, 1);
      // Drain: four entries in order, 0x40 never shows.
      tbl[16] = mk(0, 32'h0,  0, 0, 1, 32'h20, 1, 1);
      tbl[17] = mk(0, 32'h0,  0, 0, 1, 32'h21, 1, 1);
      tbl[18] = mk(0, 32'h0,  0, 0, 1, 32'h22, 1, 1);
      tbl[19] = mk(0, 32'h0,  0, 0, 1, 32'h23, 0, 1);
      tbl[20] = mk(0, 32'h0,  0, 0, 0, 32'h0,  0, 1);
      // Flush at count 3 together with a push.
      tbl[21] = mk(1, 32'h50, 1, 0, 0, 32'h0,  0, 1);
      tbl[22] = mk(1, 32'h51, 1, 0, 1, 32'h50, 0, 1);
      tbl[23] = mk(1, 32'h52, 1, 0, 1, 32'h50, 1, 1);
      tbl[24] = mk(1, 32'h53, 1, 1, 1, 32'h50, 1, 1);
      tbl[25] = mk(0, 32'h0,  0, 0, 0, 32'h0,  0, 1);
      tbl[26] = mk(1, 32'h80, 0, 0, 0, 32'h0,  0, 1);
      tbl[27] = mk(0, 32'h0,  0, 0, 1, 32'h80, 0, 1);
      tbl[28] = mk(0, 32'h0,  0, 0, 0, 32'h0,  0, 1);

      drive(0, 0, 0, 0);
      tick; tick;
      chk("rst.valid", 64'(o_valid), 64'd0);
      chk("rst.hold",  64'(o_hold),  64'd0);
      chk("rst.ovf",   64'(o_ovf),   64'd0);
      chk("rst.scnt",  64'(o_scnt),  64'd0);
      rst = 1'b0;
      tick;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].p, tbl[i].s, tbl[i].f);
         #1;
         chk($sformatf("v%0d.valid", i), 64'(o_valid), 64'(tbl[i].ev));
         chk($sformatf("v%0d.hold",  i), 64'(o_hold),  64'(tbl[i].eh));
         chk($sformatf("v%0d.ovf",   i), 64'(o_ovf),   64'(tbl[i].eo));
         if (tbl[i].ev)
            chk_head($sformatf("v%0d", i), tbl[i].ep);
         tick;
      end

      // Asynchronous reset with entries queued: clears before any clock edge.
      drive(1, 32'h90, 1, 0); tick;
      drive(1, 32'h91, 1, 0); tick;
      drive(0, 0, 1, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst.valid", 64'(o_valid), 64'd0);
      chk("arst.hold",  64'(o_hold),  64'd0);
      chk("arst.ovf",   64'(o_ovf),   64'd0);
      tick;
      rst = 1'b0;
      tick;

      // Wrap: fill to full, then push/pop every cycle, then drain.
      nxt = 32'h100;
      for (int c = 0; c < 20; c++) begin
         if (c < 4)       drive(1, nxt, 1, 0);
         else if (c < 16) drive(1, nxt, 0, 0);
         else             drive(0, 0, 0, 0);
         #1;
         mvalid = (q.size() != 0);
         chk($sformatf("w%0d.valid", c), 64'(o_valid), 64'(mvalid));
         chk($sformatf("w%0d.hold",  c), 64'(o_hold),  64'(q.size() >= 2));
         if (mvalid)
            chk_head($sformatf("w%0d", c), q[0]);
         mpop = mvalid & ~stall;
         if (ia_valid && (q.size() < 4 || mpop)) begin
            q.push_back(nxt);
         end
         if (mpop)
            void'(q.pop_front());
         if (ia_valid)
            nxt = nxt + 1;
         tick;
      end
      chk("wrap.empty", 64'(o_valid), 64'd0);
      chk("wrap.ovf",   64'(o_ovf),   64'd0);

      // Perf: 5 stalled cycles with a valid head, a flush, 2 empty stalls.
      rst = 1'b1; #1;
      chk("perf.rst", 64'(o_scnt), 64'd0);
      tick;
      rst = 1'b0;
      drive(1, 32'hA0, 1, 0); tick;
      drive(0, 0, 1, 0);
      for (int k = 0; k < 5; k++) tick;
      drive(0, 0, 0, 1); tick;
      drive(0, 0, 1, 0); tick; tick;
      drive(0, 0, 0, 0);
`ifdef STG2IF_PERF_EN
      exp_perf = 5;
`else
      exp_perf = 0;
`endif
      chk("perf.cnt",   64'(o_scnt),  64'(exp_perf));
      chk("perf.valid", 64'(o_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
